// File: rtl/seg_capture_decoder.sv
// Captures the four digits of a multiplexed 7-segment display bus, debounced over
// STABLE_CYCLES cycles, into a BCD frame. Optional binary output: `define SEG_BIN_OUT_EN.
module seg_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        sel_err,
    output logic [1:0]  dbg_state
`ifdef SEG_BIN_OUT_EN
    ,
    output logic [13:0] value_bin,
    output logic        bin_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  samp_sel;
    logic [6:0]  samp_seg;
    logic [7:0]  stab_cnt;
    logic [15:0] slots;
    logic [3:0]  mask;
    logic        acc_err;
    logic        frame_pending;
    logic        prev_multi;

    logic        sel_onehot;
    logic        sel_multi;
    logic        same;
    logic [7:0]  cnt_inc;
    logic [3:0]  dec_digit;
    logic        dec_err;
    logic [3:0]  mask_base;
    logic        acc_base;
    logic [3:0]  mask_next;

    // Returns {pattern_error, bcd_digit}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            default: decode = 5'h1E;
        endcase
    endfunction

    always_comb begin
        sel_onehot             = $onehot(dig_sel);
        sel_multi              = (dig_sel != 4'h0) && !sel_onehot;
        same                   = ({dig_sel, seg_in} == {samp_sel, samp_seg});
        cnt_inc                = stab_cnt + 8'd1;
        {dec_err, dec_digit}   = decode(samp_seg);
        // A completed frame clears on the same edge a new capture lands, so the
        // new capture must build on an empty mask/accumulator.
        mask_base              = frame_pending ? 4'h0 : mask;
        acc_base               = frame_pending ? 1'b0 : acc_err;
        mask_next              = mask_base | samp_sel;
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            samp_sel      <= 4'h0;
            samp_seg      <= 7'h00;
            stab_cnt      <= 8'd0;
            slots         <= 16'h0000;
            mask          <= 4'h0;
            acc_err       <= 1'b0;
            frame_pending <= 1'b0;
            prev_multi    <= 1'b0;
            value         <= 16'h0000;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            sel_err       <= 1'b0;
        end else begin
            prev_multi    <= sel_multi;
            sel_err       <= sel_multi && !prev_multi;
            frame_valid   <= frame_pending;
            frame_pending <= 1'b0;
            if (frame_pending) begin
                value     <= slots;
                frame_err <= acc_err;
                mask      <= 4'h0;
                acc_err   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel_onehot) begin
                        state    <= SETTLE;
                        samp_sel <= dig_sel;
                        samp_seg <= seg_in;
                        stab_cnt <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (same) begin
                        stab_cnt <= cnt_inc;
                        if (cnt_inc == 8'(STABLE_CYCLES)) begin
                            state <= HELD;
                            for (int i = 0; i < 4; i++) begin
                                if (samp_sel[i]) slots[i*4 +: 4] <= dec_digit;
                            end
                            mask          <= mask_next;
                            acc_err       <= acc_base | dec_err;
                            frame_pending <= (mask_next == 4'hF);
                        end
                    end else if (sel_onehot) begin
                        samp_sel <= dig_sel;
                        samp_seg <= seg_in;
                        stab_cnt <= 8'd1;
                    end else begin
                        state    <= IDLE;
                        stab_cnt <= 8'd0;
                    end
                end
                HELD: begin
                    if (!same) begin
                        if (sel_onehot) begin
                            state    <= SETTLE;
                            samp_sel <= dig_sel;
                            samp_seg <= seg_in;
                            stab_cnt <= 8'd1;
                        end else begin
                            state    <= IDLE;
                            stab_cnt <= 8'd0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    stab_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef SEG_BIN_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_bin <= 14'd0;
            bin_valid <= 1'b0;
        end else begin
            bin_valid <= frame_valid;
            if (frame_valid) begin
                value_bin <= 14'(value[15:12]) * 14'd1000 + 14'(value[11:8]) * 14'd100
                           + 14'(value[7:4]) * 14'd10 + 14'(value[3:0]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed bench for seg_capture_decoder: linear steps with immediate assertions.
module tb_seg_capture_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_err;
    logic        sel_err;
    logic [1:0]  dbg_state;
`ifdef SEG_BIN_OUT_EN
    logic [13:0] value_bin;
    logic        bin_valid;
`endif

    seg_capture_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel_err     (sel_err)
        ,
        .dbg_state   (dbg_state)
`ifdef SEG_BIN_OUT_EN
        ,
        .value_bin   (value_bin),
        .bin_valid   (bin_valid)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // event recorder, sampled on the falling edge
    int          cyc = 0;
    int          fv_cnt = 0;
    int          fv_cyc = 0;
    logic [15:0] fv_value = 16'h0;
    logic        fv_err = 1'b0;
    int          se_cnt = 0;
    int          bv_cnt = 0;
    int          bv_cyc = 0;
    logic [13:0] bv_val = 14'h0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (frame_valid) begin
            fv_cnt   <= fv_cnt + 1;
            fv_cyc   <= cyc;
            fv_value <= value;
            fv_err   <= frame_err;
        end
        if (sel_err) se_cnt <= se_cnt + 1;
`ifdef SEG_BIN_OUT_EN
        if (bin_valid) begin
            bv_cnt <= bv_cnt + 1;
            bv_cyc <= cyc;
            bv_val <= value_bin;
        end
`endif
    end

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // driver: hold {sel, seg} stable across n rising edges
    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0, 6);
        drive(4'b0010, s1, 6);
        drive(4'b0100, s2, 6);
        drive(4'b1000, s3, 6);
        drive(4'b0000, 7'h00, 3);
    endtask

    task automatic clear_counts();
        @(negedge clk);
        fv_cnt = 0;
        se_cnt = 0;
        bv_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        dig_sel = 4'h0;
        seg_in  = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", value, 16'h0000);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_sel_err", sel_err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // digits 1,2,3,4 -> 4321
        clear_counts();
        drive(4'b0001, 7'h06, 6);
        check("held_after_capture", dbg_state, 2'd2);
        drive(4'b0010, 7'h5B, 6);
        drive(4'b0100, 7'h4F, 6);
        drive(4'b1000, 7'h66, 6);
        drive(4'b0000, 7'h00, 3);
        check("f1_count", fv_cnt, 1);
        check("f1_value", fv_value, 16'h4321);
        check("f1_err", fv_err, 1'b0);
        check("f1_value_hold", value, 16'h4321);

        // 3 cycles only: no capture
        clear_counts();
        drive(4'b0001, 7'h3F, 3);
        check("short_settle_state", dbg_state, 2'd1);
        drive(4'b0010, 7'h07, 3);
        drive(4'b0000, 7'h00, 3);
        check("short_no_frame", fv_cnt, 0);
        check("short_value_hold", value, 16'h4321);
        // one more full frame must need all four digits again
        drive(4'b0001, 7'h7F, 6);
        drive(4'b0010, 7'h6F, 6);
        drive(4'b0100, 7'h00, 6);
        check("partial_no_frame", fv_cnt, 0);
        drive(4'b1000, 7'h07, 6);
        drive(4'b0000, 7'h00, 3);
        check("err_count", fv_cnt, 1);
        check("err_value", fv_value, 16'h7E98);
        check("err_flag", fv_err, 1'b1);

        // slot overwrite, error accumulator cleared
        clear_counts();
        drive(4'b0001, 7'h06, 6);
        drive(4'b0001, 7'h5B, 6);
        drive(4'b0010, 7'h4F, 6);
        drive(4'b0100, 7'h66, 6);
        check("overwrite_no_frame", fv_cnt, 0);
        drive(4'b1000, 7'h6D, 6);
        drive(4'b0000, 7'h00, 3);
        check("overwrite_count", fv_cnt, 1);
        check("overwrite_value", fv_value, 16'h5432);
        check("overwrite_err", fv_err, 1'b0);

        // multi-hot select
        clear_counts();
        drive(4'b0011, 7'h06, 5);
        check("multi_state", dbg_state, 2'd0);
        drive(4'b0000, 7'h00, 2);
        check("multi_sel_err_once", se_cnt, 1);
        check("multi_no_frame", fv_cnt, 0);
        check("multi_value_hold", value, 16'h5432);

        // reset mid-frame
        clear_counts();
        drive(4'b0001, 7'h06, 6);
        drive(4'b0010, 7'h5B, 6);
        drive(4'b0100, 7'h4F, 6);
        #3;
        rst_n = 1'b0;
        #1;
        check("amid_rst_value", value, 16'h0000);
        check("amid_rst_frame_valid", frame_valid, 1'b0);
        check("amid_rst_frame_err", frame_err, 1'b0);
        check("amid_rst_sel_err", sel_err, 1'b0);
        check("amid_rst_state", dbg_state, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0000, 7'h00, 2);
        drive(4'b1000, 7'h7D, 6);
        drive(4'b0000, 7'h00, 3);
        check("post_rst_no_frame", fv_cnt, 0);
        drive(4'b0001, 7'h6F, 6);
        drive(4'b0010, 7'h7F, 6);
        drive(4'b0100, 7'h07, 6);
        drive(4'b0000, 7'h00, 3);
        check("post_rst_count", fv_cnt, 1);
        check("post_rst_value", fv_value, 16'h6789);
        check("post_rst_err", fv_err, 1'b0);

`ifdef SEG_BIN_OUT_EN
        clear_counts();
        frame(7'h6D, 7'h6D, 7'h5B, 7'h3F);
        check("bin_frame_value", fv_value, 16'h0255);
        check("bin_count", bv_cnt, 1);
        check("bin_value", bv_val, 14'd255);
        check("bin_latency", bv_cyc - fv_cyc, 1);
        check("bin_hold", value_bin, 14'd255);
`else
        clear_counts();
        frame(7'h3F, 7'h06, 7'h3F, 7'h06);
        check("plain_frame_count", fv_cnt, 1);
        check("plain_frame_value", fv_value, 16'h1010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_capture_decoder.md
SEG_CAPTURE_DECODER -- requirements
Module: seg_capture_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical cycles required before a digit is captured (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 seg_in  input  7  active-high segment bus from the display driver, bit0=a through bit6=g.
REQ-005 dig_sel  input  4  active-high one-hot digit strobe; bit0 = least-significant digit.
REQ-006 value  output  16  captured four-digit BCD value, digit0 in [3:0].
REQ-007 frame_valid  output  1  one-cycle pulse when value is updated with a complete frame.
REQ-008 frame_err  output  1  qualified by frame_valid; high if any digit in the frame had an unrecognised pattern.
REQ-009 sel_err  output  1  one-cycle pulse when dig_sel is multi-hot.

Function
REQ-010 Decode table (seg_in -> BCD) shall be 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9; any other pattern, including 00, decodes to 4'hE with the pattern error flagged.
REQ-011 The FSM shall have states IDLE, SETTLE, HELD.
REQ-012 IDLE: dig_sel zero or multi-hot keeps IDLE; a one-hot dig_sel moves to SETTLE and loads stab_cnt=1 with the sampled {dig_sel, seg_in}.
REQ-013 SETTLE: an unchanged {dig_sel, seg_in} increments stab_cnt; a change reloads the sample with stab_cnt=1, or goes to IDLE if the new dig_sel is not one-hot.
REQ-014 SETTLE: the cycle stab_cnt reaches STABLE_CYCLES shall capture the decoded digit into the slot selected by dig_sel, set that slot's mask bit, OR its pattern error into the frame error accumulator, and move to HELD.
REQ-015 HELD: no further capture while {dig_sel, seg_in} is unchanged; any change behaves as the IDLE/SETTLE entry of REQ-012.
REQ-016 Recapturing a slot before the frame completes shall overwrite that slot; the mask is unchanged.
REQ-017 A capture that completes mask=4'hF shall, on the next cycle, update value from the four slots, pulse frame_valid, present frame_err, and clear the mask and accumulator.
REQ-018 If a capture occurs in the same cycle the mask and accumulator clear, the new capture shall count toward the next frame.
REQ-019 A multi-hot dig_sel shall pulse sel_err for one cycle on each cycle it is first seen (edge, not level), and shall cause no capture.
REQ-020 value shall hold between frames.

Reset
REQ-021 rst_n low shall immediately force the FSM to IDLE, stab_cnt=0, mask=0, accumulator=0, slots=0, value=16'h0000, frame_valid=0, frame_err=0, sel_err=0.
REQ-022 Reset mid-frame shall discard partial captures; the first frame after release requires all four digits.

Configuration
REQ-023 With SEG_BIN_OUT_EN defined, the module shall add output value_bin [13:0], which equals the binary value of the BCD value and is registered one cycle after frame_valid, together with output bin_valid (1), a one-cycle pulse aligned with the value_bin update; both reset to 0.
REQ-024 Without SEG_BIN_OUT_EN, the module shall have neither port and shall contain no conversion logic.

Verification
REQ-025 Digits 1,2,3,4 (seg 06,5B,4F,66) are driven on dig_sel 1,2,4,8 for 6 cycles each with STABLE_CYCLES=4 -> one frame_valid, value=16'h4321, frame_err=0.
REQ-026 A digit is held for exactly 3 cycles and then dig_sel changes -> no capture and no frame_valid.
REQ-027 seg_in=7'h00 is driven on digit2 within a full frame -> frame_err=1, value[11:8]=4'hE.
REQ-028 dig_sel=4'b0011 is held for 5 cycles -> one sel_err pulse and no capture.
REQ-029 rst_n is asserted after three digits are captured -> all outputs are 0; a fresh four-digit frame of 9,8,7,6 then yields value=16'h6789.
REQ-030 With SEG_BIN_OUT_EN, a frame of value 16'h0255 -> value_bin=14'd255 and bin_valid one cycle after frame_valid.
